// File: rtl/fat32_dir_entry_streamer.sv
// fat32_dir_entry_streamer: streams one FAT32 directory entry set (LFN entries, then the 8.3 entry)
// as bytes over a valid/ready port. Define DIR_ENTRY_TIMESTAMP_EN to add time/date stamp inputs.
module fat32_dir_entry_streamer #(
    parameter int LFN_ENTRIES = 1
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    start,
    input  logic [87:0]                                             short_name,
    input  logic [7:0]                                              attr,
    input  logic [31:0]                                             first_cluster,
    input  logic [31:0]                                             file_size,
    input  logic [((LFN_ENTRIES == 0) ? 1 : LFN_ENTRIES * 208)-1:0] long_name,
`ifdef DIR_ENTRY_TIMESTAMP_EN
    input  logic [15:0]                                             stamp_time,
    input  logic [15:0]                                             stamp_date,
`endif
    output logic                                                    busy,
    output logic [7:0]                                              out_data,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic                                                    out_last,
    output logic                                                    done
);

    localparam int         N         = LFN_ENTRIES;
    localparam int         LN_W      = (N == 0) ? 208 : N * 208;
    localparam int         LN_IW     = $clog2(LN_W);
    localparam logic [7:0] LAST_IDX  = 8'(32 * (N + 1) - 1);
    localparam logic [7:0] SFN_START = 8'(32 * N);

    typedef enum logic [2:0] {IDLE, CKSUM, LFN, SFN, DONE} state_t;

    state_t            state_q;
    logic [7:0]        byteCnt_q;
    logic [7:0]        cksum_q;
    logic [7:0]        outData_q;
    logic              outValid_q;
    logic              outLast_q;
    logic              busy_q;
    logic              done_q;
    logic [87:0]       shortName_q;
    logic [7:0]        attr_q;
    logic [31:0]       firstCluster_q;
    logic [31:0]       fileSize_q;
    logic [LN_W-1:0]   longName_q;
`ifdef DIR_ENTRY_TIMESTAMP_EN
    logic [15:0]       stampTime_q;
    logic [15:0]       stampDate_q;
`endif

    logic [7:0]        byteCnt_d;
    logic [7:0]        outData_d;
    logic [4:0]        offset;
    int                entryIdx;
    int                ordinal;
    int                charSlot;
    int                charIdx;
    logic              isChar;
    logic [15:0]       lfnChar;
    logic [LN_IW-1:0]  charBit;

    // Byte that will be presented next; while in CKSUM the next byte is the first of the stream.
    always_comb begin
        byteCnt_d = (state_q == CKSUM) ? 8'd0 : byteCnt_q + 8'd1;
        offset    = byteCnt_d[4:0];
        entryIdx  = int'(byteCnt_d[7:5]);
        ordinal   = N - entryIdx;
        charSlot  = 0;
        charIdx   = 0;
        isChar    = 1'b0;
        lfnChar   = 16'h0000;
        charBit   = '0;
        outData_d = 8'h00;
        if (entryIdx < N) begin
            if (offset >= 5'd1 && offset <= 5'd10) begin
                isChar   = 1'b1;
                charSlot = int'(offset - 5'd1);
            end else if (offset >= 5'd14 && offset <= 5'd25) begin
                isChar   = 1'b1;
                charSlot = int'(offset - 5'd14) + 10;
            end else if (offset >= 5'd28) begin
                isChar   = 1'b1;
                charSlot = int'(offset - 5'd28) + 22;
            end
            if (isChar) begin
                charIdx   = 13 * (ordinal - 1) + charSlot / 2;
                charBit   = LN_IW'(16 * charIdx);
                lfnChar   = longName_q[charBit +: 16];
                outData_d = ((charSlot % 2) == 1) ? lfnChar[15:8] : lfnChar[7:0];
            end else begin
                case (offset)
                    5'd0:    outData_d = (entryIdx == 0) ? (8'(ordinal) | 8'h40) : 8'(ordinal);
                    5'd11:   outData_d = 8'h0F;
                    5'd13:   outData_d = cksum_q;
                    default: outData_d = 8'h00;
                endcase
            end
        end else if (offset <= 5'd10) begin
            outData_d = shortName_q[{offset[3:0], 3'b000} +: 8];
        end else begin
            case (offset)
                5'd11:   outData_d = attr_q;
`ifdef DIR_ENTRY_TIMESTAMP_EN
                5'd14:   outData_d = stampTime_q[7:0];
                5'd15:   outData_d = stampTime_q[15:8];
                5'd16:   outData_d = stampDate_q[7:0];
                5'd17:   outData_d = stampDate_q[15:8];
                5'd18:   outData_d = stampDate_q[7:0];
                5'd19:   outData_d = stampDate_q[15:8];
                5'd22:   outData_d = stampTime_q[7:0];
                5'd23:   outData_d = stampTime_q[15:8];
                5'd24:   outData_d = stampDate_q[7:0];
                5'd25:   outData_d = stampDate_q[15:8];
`endif
                5'd20:   outData_d = firstCluster_q[23:16];
                5'd21:   outData_d = firstCluster_q[31:24];
                5'd26:   outData_d = firstCluster_q[7:0];
                5'd27:   outData_d = firstCluster_q[15:8];
                5'd28:   outData_d = fileSize_q[7:0];
                5'd29:   outData_d = fileSize_q[15:8];
                5'd30:   outData_d = fileSize_q[23:16];
                5'd31:   outData_d = fileSize_q[31:24];
                default: outData_d = 8'h00;
            endcase
        end
    end

    // Sequencer: outputs are registered so out_data/out_last hold naturally during stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byteCnt_q  <= 8'd0;
            cksum_q    <= 8'h00;
            outData_q  <= 8'h00;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shortName_q    <= short_name;
                        attr_q         <= attr;
                        firstCluster_q <= first_cluster;
                        fileSize_q     <= file_size;
                        longName_q     <= LN_W'(long_name);
`ifdef DIR_ENTRY_TIMESTAMP_EN
                        stampTime_q    <= stamp_time;
                        stampDate_q    <= stamp_date;
`endif
                        busy_q    <= 1'b1;
                        cksum_q   <= 8'h00;
                        byteCnt_q <= 8'd0;
                        outLast_q <= 1'b0;
                        if (N == 0) begin
                            state_q    <= SFN;
                            outValid_q <= 1'b1;
                            outData_q  <= short_name[7:0];
                        end else begin
                            state_q <= CKSUM;
                        end
                    end
                end
                CKSUM: begin
                    cksum_q <= {cksum_q[0], cksum_q[7:1]} + shortName_q[{byteCnt_q[3:0], 3'b000} +: 8];
                    if (byteCnt_q == 8'd10) begin
                        byteCnt_q  <= 8'd0;
                        state_q    <= LFN;
                        outValid_q <= 1'b1;
                        outData_q  <= outData_d;
                    end else begin
                        byteCnt_q <= byteCnt_q + 8'd1;
                    end
                end
                LFN, SFN: begin
                    if (outValid_q && out_ready) begin
                        if (byteCnt_q == LAST_IDX) begin
                            state_q    <= DONE;
                            outValid_q <= 1'b0;
                            outLast_q  <= 1'b0;
                            outData_q  <= 8'h00;
                            byteCnt_q  <= 8'd0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            byteCnt_q <= byteCnt_d;
                            outData_q <= outData_d;
                            outLast_q <= (byteCnt_d == LAST_IDX);
                            if (byteCnt_d == SFN_START) begin
                                state_q <= SFN;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fat32_dir_entry_streamer.sv
// Bench for fat32_dir_entry_streamer: three instances (0, 1 and 3 LFN entries) checked against an
// entry-level model; honours DIR_ENTRY_TIMESTAMP_EN when defined.
`timescale 1ns/1ps
module tb_fat32_dir_entry_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         st [3];
    logic [87:0]  shortName;
    logic [7:0]   attrIn;
    logic [31:0]  firstCluster;
    logic [31:0]  fileSize;
    logic [623:0] longName;
    logic         outReady;
`ifdef DIR_ENTRY_TIMESTAMP_EN
    logic [15:0]  stampTime;
    logic [15:0]  stampDate;
`endif
    logic [7:0]   od [3];
    logic         ov [3];
    logic         ol [3];
    logic         bz [3];
    logic         dn [3];

    fat32_dir_entry_streamer #(.LFN_ENTRIES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .short_name(shortName), .attr(attrIn),
        .first_cluster(firstCluster), .file_size(fileSize), .long_name(longName[0:0]),
`ifdef DIR_ENTRY_TIMESTAMP_EN
        .stamp_time(stampTime), .stamp_date(stampDate),
`endif
        .busy(bz[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(outReady),
        .out_last(ol[0]), .done(dn[0]));

    fat32_dir_entry_streamer #(.LFN_ENTRIES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .short_name(shortName), .attr(attrIn),
        .first_cluster(firstCluster), .file_size(fileSize), .long_name(longName[207:0]),
`ifdef DIR_ENTRY_TIMESTAMP_EN
        .stamp_time(stampTime), .stamp_date(stampDate),
`endif
        .busy(bz[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(outReady),
        .out_last(ol[1]), .done(dn[1]));

    fat32_dir_entry_streamer #(.LFN_ENTRIES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .short_name(shortName), .attr(attrIn),
        .first_cluster(firstCluster), .file_size(fileSize), .long_name(longName),
`ifdef DIR_ENTRY_TIMESTAMP_EN
        .stamp_time(stampTime), .stamp_date(stampDate),
`endif
        .busy(bz[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(outReady),
        .out_last(ol[2]), .done(dn[2]));

    int         checks;
    int         errors;
    logic [7:0] expB [3][160];
    int         expLen [3];
    logic [7:0] cap [3][160];
    logic [7:0] saved [64];
    int         rxCnt [3];
    logic       armed [3];
    logic       donePend [3];
    logic       stallPend [3];
    logic       stallLast [3];
    logic [7:0] stallData [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int entriesOf(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    // Whole-entry model: build every 32-byte entry from the current inputs.
    task automatic buildExpected(input int d);
        int n, sum, base, ord;
        int charPos [13];
        logic [15:0] c;
        charPos = '{1, 3, 5, 7, 9, 14, 16, 18, 20, 22, 24, 28, 30};
        n = entriesOf(d);
        sum = 0;
        for (int k = 0; k < 11; k++)
            sum = (((sum >> 1) | (sum << 7)) + int'(shortName[8*k +: 8])) & 255;
        expLen[d] = 32 * (n + 1);
        for (int i = 0; i < 160; i++) expB[d][i] = 8'h00;
        for (int e = 0; e < n; e++) begin
            ord  = n - e;
            base = 32 * e;
            expB[d][base]      = 8'(ord) | ((e == 0) ? 8'h40 : 8'h00);
            expB[d][base + 11] = 8'h0F;
            expB[d][base + 13] = 8'(sum);
            for (int j = 0; j < 13; j++) begin
                c = longName[16 * (13 * (ord - 1) + j) +: 16];
                expB[d][base + charPos[j]]     = c[7:0];
                expB[d][base + charPos[j] + 1] = c[15:8];
            end
        end
        base = 32 * n;
        for (int k = 0; k < 11; k++) expB[d][base + k] = shortName[8*k +: 8];
        expB[d][base + 11] = attrIn;
        expB[d][base + 20] = firstCluster[23:16];
        expB[d][base + 21] = firstCluster[31:24];
        expB[d][base + 26] = firstCluster[7:0];
        expB[d][base + 27] = firstCluster[15:8];
        for (int k = 0; k < 4; k++) expB[d][base + 28 + k] = fileSize[8*k +: 8];
`ifdef DIR_ENTRY_TIMESTAMP_EN
        expB[d][base + 14] = stampTime[7:0];  expB[d][base + 15] = stampTime[15:8];
        expB[d][base + 16] = stampDate[7:0];  expB[d][base + 17] = stampDate[15:8];
        expB[d][base + 18] = stampDate[7:0];  expB[d][base + 19] = stampDate[15:8];
        expB[d][base + 22] = stampTime[7:0];  expB[d][base + 23] = stampTime[15:8];
        expB[d][base + 24] = stampDate[7:0];  expB[d][base + 25] = stampDate[15:8];
`endif
    endtask

    // Compare process: every cycle, each instance is either idle, streaming, or pulsing done.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 3; d++) begin
                if (donePend[d]) begin
                    check($sformatf("done%0d", d), {30'd0, dn[d], bz[d]}, 32'h2);
                    donePend[d] = 1'b0;
                    armed[d]    = 1'b0;
                end else if (armed[d]) begin
                    check($sformatf("busy%0d", d), {30'd0, bz[d], dn[d]}, 32'h2);
                    if (stallPend[d]) begin
                        check($sformatf("stall%0d", d), {22'd0, ov[d], ol[d], od[d]},
                              {22'd0, 1'b1, stallLast[d], stallData[d]});
                        stallPend[d] = 1'b0;
                    end
                    if (rxCnt[d] > 0)
                        check($sformatf("bubble%0d", d), {31'd0, ov[d]}, 32'd1);
                    if (ov[d] === 1'b1) begin
                        if (outReady) begin
                            check($sformatf("data%0d[%0d]", d, rxCnt[d]), {24'd0, od[d]},
                                  {24'd0, expB[d][rxCnt[d]]});
                            check($sformatf("last%0d[%0d]", d, rxCnt[d]), {31'd0, ol[d]},
                                  {31'd0, (rxCnt[d] == expLen[d] - 1)});
                            cap[d][rxCnt[d]] = od[d];
                            rxCnt[d]++;
                            if (rxCnt[d] == expLen[d]) donePend[d] = 1'b1;
                        end else begin
                            stallPend[d] = 1'b1;
                            stallData[d] = od[d];
                            stallLast[d] = ol[d];
                        end
                    end
                end else begin
                    check($sformatf("idle%0d", d), {30'd0, ov[d], dn[d]}, 32'd0);
                end
            end
        end
    end

    task automatic setLongName(input int len);
        for (int i = 0; i < 39; i++)
            longName[16*i +: 16] = (i < len) ? 16'h0041 + 16'(i) : (i == len) ? 16'h0000 : 16'hFFFF;
    endtask

    task automatic applyStimulus(input int variant);
        if (variant == 0) begin
            shortName    = {11{8'h20}};
            attrIn       = 8'h20;
            firstCluster = 32'h12345678;
            fileSize     = 32'h00000200;
            setLongName(9);
        end else begin
            for (int k = 0; k < 11; k++) shortName[8*k +: 8] = 8'h41 + 8'(k);
            attrIn       = 8'h01;
            firstCluster = 32'h0000ABCD;
            fileSize     = 32'h00012345;
            setLongName(30);
        end
`ifdef DIR_ENTRY_TIMESTAMP_EN
        stampTime = 16'hA5C3;
        stampDate = 16'h5A21;
`endif
    endtask

    task automatic scrambleInputs();
        shortName    = ~shortName;
        attrIn       = ~attrIn;
        firstCluster = firstCluster ^ 32'hDEADBEEF;
        fileSize     = ~fileSize;
        longName     = ~longName;
`ifdef DIR_ENTRY_TIMESTAMP_EN
        stampTime    = ~stampTime;
        stampDate    = ~stampDate;
`endif
    endtask

    task automatic runJob(input int d, input bit rnd, input int abortAt, input bit dblStart);
        int lat, cyc;
        bit seen, dblDone;
        buildExpected(d);
        outReady = 1'b1;
        st[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
        rxCnt[d] = 0; stallPend[d] = 1'b0; donePend[d] = 1'b0; armed[d] = 1'b1;
        scrambleInputs();
        lat = 1; cyc = 0; seen = 1'b0; dblDone = 1'b0;
        while ((armed[d] || donePend[d]) && cyc < 3000) begin
            st[d] = 1'b0;
            if (!seen && ov[d] === 1'b1) begin
                seen = 1'b1;
                check($sformatf("latency%0d", d), lat, (d == 0) ? 1 : 12);
            end
            if (dblStart && !dblDone && rxCnt[d] == 5) begin
                st[d]   = 1'b1;
                dblDone = 1'b1;
            end
            if (abortAt >= 0 && rxCnt[d] == abortAt && ov[d] === 1'b1) begin
                rst_n = 1'b0; outReady = 1'b0; armed[d] = 1'b0; stallPend[d] = 1'b0;
                @(posedge clk); #1;
                check($sformatf("abort%0d", d), {29'd0, ov[d], bz[d], dn[d]}, 32'd0);
                rst_n = 1'b1;
                break;
            end
            outReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            lat++; cyc++;
        end
        st[d] = 1'b0;
        check($sformatf("count%0d", d), rxCnt[d], (abortAt >= 0) ? abortAt : expLen[d]);
        armed[d] = 1'b0; donePend[d] = 1'b0;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        check(name, {24'd0, act}, {24'd0, exp});
    endtask

    initial begin
        int diffs;
        checks = 0; errors = 0;
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0; armed[d] = 1'b0; donePend[d] = 1'b0; stallPend[d] = 1'b0;
            rxCnt[d] = 0; stallLast[d] = 1'b0; stallData[d] = 8'h00; expLen[d] = 0;
            for (int i = 0; i < 160; i++) cap[d][i] = 8'h00;
        end
        outReady = 1'b1;
        rst_n = 1'b0;
        applyStimulus(0);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("rst_data%0d", d), od[d], 8'h00);
            check($sformatf("rst_flags%0d", d), {28'd0, ov[d], ol[d], bz[d], dn[d]}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // One LFN entry, all-space short name, ready held high.
        applyStimulus(0);
        runJob(1, 1'b0, -1, 1'b0);
        checkOutput("j1_ord", cap[1][0], 8'h41);
        checkOutput("j1_c0", cap[1][1], 8'h41);
        checkOutput("j1_attr", cap[1][11], 8'h0F);
        checkOutput("j1_cksum", cap[1][13], 8'hF7);
        checkOutput("j1_pad", cap[1][24], 8'hFF);
        checkOutput("j1_fc20", cap[1][52], 8'h34);
        checkOutput("j1_fc21", cap[1][53], 8'h12);
        checkOutput("j1_fc26", cap[1][58], 8'h78);
        checkOutput("j1_fc27", cap[1][59], 8'h56);
        checkOutput("j1_sz29", cap[1][61], 8'h02);
        checkOutput("j1_sz28", cap[1][60], 8'h00);
`ifdef DIR_ENTRY_TIMESTAMP_EN
        checkOutput("j1_t14", cap[1][46], 8'hC3);
        checkOutput("j1_t15", cap[1][47], 8'hA5);
        checkOutput("j1_d16", cap[1][48], 8'h21);
        checkOutput("j1_d17", cap[1][49], 8'h5A);
        checkOutput("j1_d24", cap[1][56], 8'h21);
        checkOutput("j1_d25", cap[1][57], 8'h5A);
`else
        checkOutput("j1_t14", cap[1][46], 8'h00);
`endif
        for (int i = 0; i < 64; i++) saved[i] = cap[1][i];

        // Same job with a random out_ready pattern must yield the identical byte sequence.
        applyStimulus(0);
        runJob(1, 1'b1, -1, 1'b0);
        diffs = 0;
        for (int i = 0; i < 64; i++) if (cap[1][i] !== saved[i]) diffs++;
        check("j2_same_seq", diffs, 0);

        // No LFN entries: streaming starts the cycle after start.
        applyStimulus(1);
        runJob(0, 1'b1, -1, 1'b0);
        checkOutput("j3_name0", cap[0][0], 8'h41);
        checkOutput("j3_attr", cap[0][11], 8'h01);
        checkOutput("j3_fc26", cap[0][26], 8'hCD);
        checkOutput("j3_sz30", cap[0][30], 8'h01);

        // Three LFN entries with a stray start while busy.
        applyStimulus(1);
        runJob(2, 1'b1, -1, 1'b1);
        checkOutput("j4_ord0", cap[2][0], 8'h43);
        checkOutput("j4_ord1", cap[2][32], 8'h02);
        checkOutput("j4_ord2", cap[2][64], 8'h01);
        checkOutput("j4_c26", cap[2][1], 8'h5B);

        // Reset at byte 40 aborts; a fresh job afterwards streams completely.
        applyStimulus(1);
        runJob(1, 1'b0, 40, 1'b0);
        applyStimulus(0);
        runJob(1, 1'b0, -1, 1'b0);
        checkOutput("j6_cksum", cap[1][13], 8'hF7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
